fifo_rptr_empty: RTL and testbench
==================================

// Module: fifo_rptr_empty
// PURPOSE
//   Read-side pointer and empty-flag generator for the dual-clock gray-pointer FIFO.
//   - Holds the binary read pointer and drives the RAM read address.
//   - Exports a registered gray read pointer to the write-domain synchroniser.
//   - Compares the next read pointer with the synchronised write pointer to set a registered empty flag.
//   - Pairs with the write-side full-flag logic: same pointer width, same gray encoding.
// PARAMETERS
//   ADDR_SIZE      4   RAM address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits
//   AEMPTY_THRESH  2   almost-empty threshold in words, 0..2**ADDR_SIZE (used only with the macro)
// PORTS
//   rclk           in   1            read clock; the only clock in the block
//   rrst           in   1            asynchronous, active-high reset
//   rinc           in   1            read request from the consumer
//   rq2_wptr       in   ADDR_SIZE+1  write pointer (gray), already synchronised into rclk
//   raddr          out  ADDR_SIZE    RAM read address = rbin[ADDR_SIZE-1:0]
//   rptr           out  ADDR_SIZE+1  registered gray read pointer, sent to the write domain
//   rempty         out  1            registered empty flag
//   ralmost_empty  out  1            registered almost-empty flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rrst=1, async assert, removal on rclk)
//     - rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1.
//     - Asserting rrst mid-operation forces these values immediately, with no wait for rclk.
//   Pointer update
//     - rbin_next = rbin + (rinc & ~rempty), modulo 2**(ADDR_SIZE+1).
//     - rgray_next = rbin_next ^ (rbin_next >> 1).
//     - On each rclk edge: rbin <= rbin_next and rptr <= rgray_next.
//     - raddr comes straight from the rbin register (no combinational path from rinc).
//     - Read-data contract: RAM data at raddr is valid while rempty=0, and is consumed by the edge where rinc=1.
//   Underflow
//     - rinc while rempty=1 is ignored: pointers hold and no error is raised.
//   Empty flag
//     - rempty <= (rgray_next == rq2_wptr).
//     - rempty asserts on the same edge that consumes the last word.
//     - rempty deasserts one rclk after rq2_wptr changes away from the current read pointer (plus synchroniser delay upstream).
//     - rempty is pessimistic: it may read 1 while data exists, and must never read 0 on an empty FIFO.
//   Wrap-around
//     - The extra MSB toggles each pass. Gray increment 2**(ADDR_SIZE+1)-1 -> 0 changes exactly one bit.
//     - raddr wraps 2**ADDR_SIZE-1 -> 0.
//   Simultaneous events
//     - rinc together with a new rq2_wptr value: the compare always uses rgray_next, so the flag reflects both.
// CONFIGURATION
//   Macro FIFO_RPTR_ALMOST_EMPTY_EN
//   - Defined:
//     - rq2_wptr is converted gray->binary into wbin_s.
//     - level = wbin_s - rbin_next (ADDR_SIZE+1 bits, modulo).
//     - ralmost_empty <= (level <= AEMPTY_THRESH).
//     - Reset value 1. Same pessimism rule as rempty.
//   - Undefined: the port stays in the interface, tied to rempty. No gray->binary logic is built.
// STRUCTURE
//   Package fifo_pkg
//     - function bin2gray(ptr), function gray2bin(ptr), parameterised by pointer width.
//     - typedef ptr_t = logic [ADDR_SIZE:0], shared with the write-side logic.
//   Sub-module
//     - fifo_gray2bin (XOR prefix chain), instantiated only under FIFO_RPTR_ALMOST_EMPTY_EN.
//     - Pointer register and compare logic stay flat in this module.
// TESTING (ADDR_SIZE=4, AEMPTY_THRESH=2)
//   1. rrst=1 mid-stream with rempty=0
//      -> rempty=1, rptr=5'b00000, raddr=0 at once, without an rclk edge.
//   2. rq2_wptr=5'b00010 (gray 3), rinc=0
//      -> rempty falls 1 cycle later.
//      Then rinc=1 for 3 cycles
//      -> raddr 0,1,2; rempty=1 on the 3rd edge; rptr=5'b00010.
//   3. rinc=1 held 4 cycles while empty
//      -> rptr, raddr, rempty unchanged.
//   4. Walk the pointer to rbin=31 (rptr=5'b10000), rq2_wptr one ahead, then read
//      -> rptr=5'b00000, raddr 15->0, rempty=1.
//   5. Macro on; rq2_wptr=5'b00111 (gray 5); read one word per cycle
//      -> ralmost_empty 0 at level 5,4,3, and 1 from level 2 down.
//      Macro off -> ralmost_empty==rempty every cycle.
//   6. rinc=1 on the same edge that rq2_wptr advances by one from the empty state
//      -> rempty stays 1 and rptr holds; next cycle rempty=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer types and gray/binary helpers for the dual-clock gray-pointer FIFO.
// Both the read-side and write-side pointer logic use these definitions.
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE = 4;

    typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

    // Helpers work on zero-extended 32-bit values, so any pointer width up to 32 bits fits.
    function automatic logic [31:0] bin2gray(input logic [31:0] ptr);
        return ptr ^ (ptr >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] ptr);
        logic [31:0] bin;
        bin = ptr;
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ ptr[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray to binary converter for a W-bit pointer.
// Each binary bit is the XOR of all gray bits at or above its position.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, RAM read address and registered empty flag for the gray-pointer FIFO.
// Optional almost-empty flag built when FIFO_RPTR_ALMOST_EMPTY_EN is defined.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = FIFO_ADDR_SIZE,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 ralmost_empty
);

    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] rbin_next;
    logic [ADDR_SIZE:0] rgray_next;
    logic               rempty_next;

    // Reads while empty are dropped, so the pointer can never pass the write pointer.
    always_comb begin
        rbin_next   = rbin + {{ADDR_SIZE{1'b0}}, (rinc & ~rempty)};
        rgray_next  = rbin_next ^ (rbin_next >> 1);
        rempty_next = (rgray_next == rq2_wptr);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= rempty_next;
        end
    end

    assign raddr = rbin[ADDR_SIZE-1:0];

`ifdef FIFO_RPTR_ALMOST_EMPTY_EN
    localparam logic [ADDR_SIZE:0] THRESH = (ADDR_SIZE+1)'(AEMPTY_THRESH);

    logic [ADDR_SIZE:0] wbin_s;
    logic [ADDR_SIZE:0] level;
    logic               ralmost_empty_q;

    fifo_gray2bin #(
        .W (ADDR_SIZE + 1)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // Level is taken against the post-read pointer, matching the empty compare.
    assign level = wbin_s - rbin_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            ralmost_empty_q <= 1'b1;
        end else begin
            ralmost_empty_q <= (level <= THRESH);
        end
    end

    assign ralmost_empty = ralmost_empty_q;
`else
    assign ralmost_empty = rempty;
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomised and directed bench for fifo_rptr_empty against an occupancy-count model.
// Build with FIFO_RPTR_ALMOST_EMPTY_EN defined to also check the almost-empty threshold.
module tb_fifo_rptr_empty;

    localparam int ADDR_SIZE     = 4;
    localparam int AEMPTY_THRESH = 2;
    localparam int PTR_MOD       = 32;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words written and read as counts modulo the pointer range.
    int m_w;
    int m_r;
    bit m_empty;
    bit m_aempty;

    fifo_rptr_empty #(
        .ADDR_SIZE     (ADDR_SIZE),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int occupancy();
        return (m_w - m_r + PTR_MOD) % PTR_MOD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".raddr"}, 32'(raddr), 32'(m_r % 16));
        check({tag, ".rptr"}, 32'(rptr), 32'(to_gray(m_r)));
        check({tag, ".rempty"}, 32'(rempty), 32'(m_empty));
`ifdef FIFO_RPTR_ALMOST_EMPTY_EN
        check({tag, ".ralmost"}, 32'(ralmost_empty), 32'(m_aempty));
`else
        check({tag, ".ralmost"}, 32'(ralmost_empty), 32'(rempty));
`endif
    endtask

    task automatic set_w(input int w);
        m_w      = w % PTR_MOD;
        rq2_wptr = to_gray(m_w);
    endtask

    // One rclk edge: the model consumes the inputs seen at the edge, then outputs are compared.
    task automatic tick(input string tag);
        @(posedge rclk);
        if (rinc && !m_empty) m_r = (m_r + 1) % PTR_MOD;
        m_empty  = (occupancy() == 0);
        m_aempty = (occupancy() <= AEMPTY_THRESH);
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_r      = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
    endtask

    initial begin
        rrst = 1'b1;
        rinc = 1'b0;
        set_w(0);
        model_reset();
        #12;
        check_outputs("reset");
        rrst = 1'b0;
        tick("idle");

        // Three words arrive, then three reads drain them.
        set_w(3);
        tick("wptr3");
        check("fill.rempty_low", 32'(rempty), 32'd0);
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain.raddr_pre", 32'(raddr), 32'(i));
            tick("drain");
        end
        check("drain.rptr", 32'(rptr), 32'h02);

        // Underflow: reads while empty are ignored.
        for (int i = 0; i < 4; i++) tick("underflow");
        check("underflow.rptr", 32'(rptr), 32'h02);

        // Asynchronous reset mid-stream while non-empty.
        rinc = 1'b0;
        set_w(8);
        tick("pre_rst");
        #2;
        rrst = 1'b1;
        #1;
        model_reset();
        check("async_rst.rempty", 32'(rempty), 32'd1);
        check("async_rst.rptr", 32'(rptr), 32'd0);
        check("async_rst.raddr", 32'(raddr), 32'd0);
        set_w(0);
        @(negedge rclk);
        rrst = 1'b0;
        tick("post_rst");

        // Walk the pointer to 31, then read across the wrap.
        rinc = 1'b1;
        while (m_r != 31) begin
            set_w(m_r + 1);
            tick("walk");
        end
        rinc = 1'b0;
        tick("at31");
        check("wrap.rptr31", 32'(rptr), 32'h10);
        set_w(0);
        tick("wrap_fill");
        rinc = 1'b1;
        tick("wrap");
        check("wrap.rptr0", 32'(rptr), 32'd0);
        check("wrap.rempty", 32'(rempty), 32'd1);

        // Five words, drained one per cycle: exercises the almost-empty threshold.
        rinc = 1'b0;
        set_w(5);
        tick("lvl5");
        rinc = 1'b1;
        for (int i = 0; i < 5; i++) tick("level_drain");

        // Read request on the edge before the write pointer moves from empty.
        rinc = 1'b1;
        tick("simul_a");
        check("simul.rempty_hold", 32'(rempty), 32'd1);
        set_w(m_w + 1);
        rinc = 1'b0;
        tick("simul_b");
        check("simul.rempty_low", 32'(rempty), 32'd0);

        // Random traffic; writer never overfills the 16-word RAM.
        for (int i = 0; i < 400; i++) begin
            rinc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && occupancy() < 16) set_w(m_w + 1);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
